// File: rtl/vga_timing_ctrl_if.sv
// Pixel timing bus shared between the timing master and downstream draw stages.
interface vga_if;
  logic [10:0] vcount;
  logic        vsync;
  logic        vblnk;
  logic [10:0] hcount;
  logic        hsync;
  logic        hblnk;
  logic [11:0] rgb;

  modport out (output vcount, vsync, vblnk, hcount, hsync, hblnk, rgb);
  modport in  (input  vcount, vsync, vblnk, hcount, hsync, hblnk, rgb);
endinterface

// File: rtl/vga_timing_ctrl.sv
// VGA timing master: horizontal/vertical counters, blanking and sync decode,
// line/frame strobes and a frame counter. Advances only on pix_en cycles.
// Flags are decoded from the next count values so they stay aligned with the
// registered counts they describe.
module vga_timing_ctrl #(
  parameter int unsigned H_ACTIVE = 800,
  parameter int unsigned H_FP     = 40,
  parameter int unsigned H_SYNC   = 128,
  parameter int unsigned H_BP     = 88,
  parameter int unsigned V_ACTIVE = 600,
  parameter int unsigned V_FP     = 1,
  parameter int unsigned V_SYNC   = 4,
  parameter int unsigned V_BP     = 23,
  parameter bit          SYNC_POL = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pix_en,
  vga_if.out          vout,
  output logic        line_start,
  output logic        frame_start,
  output logic [15:0] frame_cnt
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  // Thresholds are 12 bits wide so a sync window ending exactly at 2048 still compares correctly.
  localparam logic [11:0] H_LAST     = 12'(H_TOTAL - 1);
  localparam logic [11:0] V_LAST     = 12'(V_TOTAL - 1);
  localparam logic [11:0] H_BLANK_AT = 12'(H_ACTIVE);
  localparam logic [11:0] V_BLANK_AT = 12'(V_ACTIVE);
  localparam logic [11:0] H_SYNC_ON  = 12'(H_ACTIVE + H_FP);
  localparam logic [11:0] H_SYNC_OFF = 12'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [11:0] V_SYNC_ON  = 12'(V_ACTIVE + V_FP);
  localparam logic [11:0] V_SYNC_OFF = 12'(V_ACTIVE + V_FP + V_SYNC);

  if ((H_TOTAL > 2048) || (V_TOTAL > 2048)) begin : g_bad_mode
    $error("vga_timing_ctrl: H_TOTAL and V_TOTAL must not exceed 2048");
  end

  logic [10:0] hcount_q, hcount_d;
  logic [10:0] vcount_q, vcount_d;
  logic        hblnk_q, hblnk_d;
  logic        vblnk_q, vblnk_d;
  logic        hsync_q, hsync_d;
  logic        vsync_q, vsync_d;
  logic        line_start_q, line_start_d;
  logic        frame_start_q, frame_start_d;
  logic [15:0] frame_cnt_q, frame_cnt_d;

  logic        h_wrap;
  logic        v_wrap;
  logic [11:0] hcount_ext;
  logic [11:0] vcount_ext;
  logic        h_in_sync;
  logic        v_in_sync;

  // Next-state: counters, strobes and flag decode on the upcoming count values.
  always_comb begin
    h_wrap        = ({1'b0, hcount_q} == H_LAST);
    v_wrap        = ({1'b0, vcount_q} == V_LAST);
    hcount_d      = hcount_q;
    vcount_d      = vcount_q;
    hblnk_d       = hblnk_q;
    vblnk_d       = vblnk_q;
    hsync_d       = hsync_q;
    vsync_d       = vsync_q;
    line_start_d  = 1'b0;
    frame_start_d = 1'b0;
    frame_cnt_d   = frame_cnt_q;
    hcount_ext    = '0;
    vcount_ext    = '0;
    h_in_sync     = 1'b0;
    v_in_sync     = 1'b0;

    if (pix_en) begin
      hcount_d = h_wrap ? 11'd0 : hcount_q + 11'd1;
      if (h_wrap) begin
        vcount_d = v_wrap ? 11'd0 : vcount_q + 11'd1;
      end
      line_start_d  = h_wrap;
      frame_start_d = h_wrap & v_wrap;
      frame_cnt_d   = frame_cnt_q + {15'd0, h_wrap & v_wrap};

      hcount_ext = {1'b0, hcount_d};
      vcount_ext = {1'b0, vcount_d};
      h_in_sync  = (hcount_ext >= H_SYNC_ON) && (hcount_ext < H_SYNC_OFF);
      v_in_sync  = (vcount_ext >= V_SYNC_ON) && (vcount_ext < V_SYNC_OFF);
      hblnk_d    = (hcount_ext >= H_BLANK_AT);
      vblnk_d    = (vcount_ext >= V_BLANK_AT);
      hsync_d    = SYNC_POL ? h_in_sync : ~h_in_sync;
      vsync_d    = SYNC_POL ? v_in_sync : ~v_in_sync;
    end
  end

  // State registers; reset returns to the top-left position with syncs inactive.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hcount_q      <= '0;
      vcount_q      <= '0;
      hblnk_q       <= 1'b0;
      vblnk_q       <= 1'b0;
      hsync_q       <= ~SYNC_POL;
      vsync_q       <= ~SYNC_POL;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      frame_cnt_q   <= '0;
    end else begin
      hcount_q      <= hcount_d;
      vcount_q      <= vcount_d;
      hblnk_q       <= hblnk_d;
      vblnk_q       <= vblnk_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
      frame_cnt_q   <= frame_cnt_d;
    end
  end

  assign vout.hcount = hcount_q;
  assign vout.vcount = vcount_q;
  assign vout.hblnk  = hblnk_q;
  assign vout.vblnk  = vblnk_q;
  assign vout.hsync  = hsync_q;
  assign vout.vsync  = vsync_q;
  // Background is black; draw stages overwrite rgb further down the pipeline.
  assign vout.rgb    = 12'h000;

  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;
  assign frame_cnt   = frame_cnt_q;

endmodule
